// File: rtl/dom_mask_rng_pkg.sv
// Shared constants and state encoding for the DOM GF(2^2) mask generator.
package dom_mask_rng_pkg;

    localparam int          SHARE_W      = 2;
    localparam int          LFSR_W_DEF   = 16;
    localparam logic [15:0] TAPS_DEF     = 16'hB400;
    localparam logic [15:0] SEED_DEF     = 16'hACE1;
    localparam int          WARMUP_DEF   = 32;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_RUN    = 2'd2
    } state_e;

endpackage

// File: rtl/galois_lfsr_step.sv
// Combinational Galois LFSR advance by STEPS shifts (right shift, TAPS folded in on lsb=1).
module galois_lfsr_step #(
    parameter int                LFSR_W = 16,
    parameter logic [LFSR_W-1:0] TAPS   = 16'hB400,
    parameter int                STEPS  = 1
) (
    input  logic [LFSR_W-1:0] s_in,
    output logic [LFSR_W-1:0] s_out
);

    generate
        for (genvar gi = 0; gi < STEPS; gi++) begin : g_step
            logic [LFSR_W-1:0] s_cur;
            logic [LFSR_W-1:0] s_nxt;
            if (gi == 0) begin : g_first
                assign s_cur = s_in;
            end else begin : g_chain
                assign s_cur = g_step[gi-1].s_nxt;
            end
            assign s_nxt = (s_cur >> 1) ^ (s_cur[0] ? TAPS : '0);
        end
    endgenerate

    assign s_out = g_step[STEPS-1].s_nxt;

endmodule

// File: rtl/dom_mask_rng.sv
// Fresh Z0/Z1 mask source for the DOM GF(2^2) multiplier: seeded LFSR, warm-up FSM,
// valid/ready handshake delivering one 4-bit word per accepted transfer.
module dom_mask_rng
    import dom_mask_rng_pkg::*;
#(
    parameter int                LFSR_W       = LFSR_W_DEF,
    parameter logic [LFSR_W-1:0] TAPS         = TAPS_DEF,
    parameter logic [LFSR_W-1:0] SEED_DEFAULT = SEED_DEF,
    parameter int                WARMUP_CYC   = WARMUP_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                seed_load,
    input  logic [LFSR_W-1:0]   seed,
    input  logic                z_ready,
    output logic [SHARE_W-1:0]  z0,
    output logic [SHARE_W-1:0]  z1,
    output logic                z_valid,
    output logic                busy,
    output logic                lock_err
);

    localparam logic [7:0] WARM_LAST = 8'(WARMUP_CYC - 1);

    state_e            state_q, state_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic [7:0]        warm_cnt_q, warm_cnt_d;
    logic              lock_err_q, lock_err_d;
    logic [LFSR_W-1:0] step1_s, step4_s;

    galois_lfsr_step #(.LFSR_W(LFSR_W), .TAPS(TAPS), .STEPS(1)) u_step1 (
        .s_in  (lfsr_q),
        .s_out (step1_s)
    );

    galois_lfsr_step #(.LFSR_W(LFSR_W), .TAPS(TAPS), .STEPS(4)) u_step4 (
        .s_in  (lfsr_q),
        .s_out (step4_s)
    );

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        warm_cnt_d = warm_cnt_q;
        lock_err_d = lock_err_q;

        case (state_q)
            ST_LOAD: begin
                warm_cnt_d = '0;
                state_d    = ST_WARMUP;
            end
            ST_WARMUP: begin
                lfsr_d     = step1_s;
                warm_cnt_d = warm_cnt_q + 8'd1;
                if (warm_cnt_q == WARM_LAST) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (z_ready) begin
                    lfsr_d = step4_s;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // An all-zero state can only come from a fault; recover and flag it.
        if (state_q != ST_LOAD && lfsr_q == '0) begin
            lock_err_d = 1'b1;
            lfsr_d     = SEED_DEFAULT;
            state_d    = ST_LOAD;
        end

        // Reseed overrides everything, including a same-cycle handshake.
        if (seed_load) begin
            lfsr_d  = (seed == '0) ? SEED_DEFAULT : seed;
            state_d = ST_LOAD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_LOAD;
            lfsr_q     <= SEED_DEFAULT;
            warm_cnt_q <= '0;
            lock_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            warm_cnt_q <= warm_cnt_d;
            lock_err_q <= lock_err_d;
        end
    end

    // Masks are gated while invalid so no stale or seed bits leak to the multiplier.
    assign z_valid  = (state_q == ST_RUN);
    assign busy     = (state_q != ST_RUN);
    assign z0       = z_valid ? lfsr_q[1:0] : '0;
    assign z1       = z_valid ? lfsr_q[3:2] : '0;
    assign lock_err = lock_err_q;

endmodule
